// File: rtl/dog_pyramid_align_if.sv
// dog_pyramid_align_if: pixel stream bus between the skewed Gaussian source and the aligned DoG consumer
interface dog_pyramid_align_if #(
   parameter int DW         = 9,
   parameter int NUM_SCALES = 4
);
   logic                                iValid;
   logic                                iSof;
   logic                                iAbsMode;
   logic [NUM_SCALES*DW-1:0]            iGaussData;
   logic                                oValid;
   logic                                oSof;
   logic [NUM_SCALES*DW-1:0]            oGaussData;
   logic [(NUM_SCALES-1)*(DW+1)-1:0]    oDogData;
   logic                                oFrameDone;
   logic                                oSofErr;
   modport master (
      output iValid, iSof, iAbsMode, iGaussData,
      input  oValid, oSof, oGaussData, oDogData, oFrameDone, oSofErr
   );
   modport slave (
      input  iValid, iSof, iAbsMode, iGaussData,
      output oValid, oSof, oGaussData, oDogData, oFrameDone, oSofErr
   );
endinterface

// File: rtl/dog_pyramid_align.sv
// dog_pyramid_align: deskews Gaussian scales, forms difference-of-Gaussian planes and tracks frame framing
module dog_pyramid_align #(
   parameter int DW           = 9,
   parameter int NUM_SCALES   = 4,
   parameter int SKEW         = 2,
   parameter int FRAME_PIXELS = 307200
)(
   input logic             iclk,
   input logic             irst_n,
   dog_pyramid_align_if.slave bus
);
   localparam int N  = NUM_SCALES;
   localparam int OW = DW + 1;
   localparam int D  = (N - 1) * SKEW;

   logic                  alValid;
   logic                  alSof;
   logic [N*DW-1:0]       alGauss;
   logic                  modeReg;
   logic                  effMode;
   logic [(N-1)*OW-1:0]   dogNext;
   logic [23:0]           cnt;
   logic [23:0]           cntNext;
   logic                  errSet;
   logic                  doneNext;

   generate
      if (D == 0) begin : gDirect
         assign alValid = bus.iValid;
         assign alSof   = bus.iSof;
         assign alGauss = bus.iGaussData;
      end else begin : gAlign
         logic [D-1:0] vPipe;
         logic [D-1:0] sPipe;
         // valid/sof delay line; cleared on reset so no in-flight pixel survives it
         always_ff @(posedge iclk or negedge irst_n) begin
            if (!irst_n) begin
               vPipe <= '0;
               sPipe <= '0;
            end else begin
               vPipe <= D'({vPipe, bus.iValid});
               sPipe <= D'({sPipe, bus.iSof});
            end
         end
         assign alValid = vPipe[D-1];
         assign alSof   = sPipe[D-1];
         for (genvar k = 0; k < N; k++) begin : gScale
            localparam int DK = (N - 1 - k) * SKEW;
            if (DK == 0) begin : gPass
               assign alGauss[k*DW +: DW] = bus.iGaussData[k*DW +: DW];
            end else begin : gDelay
               logic [DW-1:0] dl [DK];
               // free-running per-scale delay so early scales wait for the last one
               always_ff @(posedge iclk) begin
                  dl[0] <= bus.iGaussData[k*DW +: DW];
                  for (int i = 1; i < DK; i++) dl[i] <= dl[i-1];
               end
               assign alGauss[k*DW +: DW] = dl[DK-1];
            end
         end
      end
   endgenerate

   // the start pixel uses the live mode bit; the rest of the frame uses the latched one
   assign effMode = alSof ? bus.iAbsMode : modeReg;

   generate
      for (genvar k = 0; k < N - 1; k++) begin : gDog
         logic [OW-1:0] diff;
         assign diff = {1'b0, alGauss[(k+1)*DW +: DW]} - {1'b0, alGauss[k*DW +: DW]};
         assign dogNext[k*OW +: OW] = (effMode && diff[OW-1]) ? -diff : diff;
      end
   endgenerate

   // frame counter next state, end-of-frame detection and framing-error detection
   always_comb begin
      cntNext  = cnt;
      errSet   = 1'b0;
      doneNext = 1'b0;
      if (alValid) begin
         if (alSof) begin
            errSet  = (cnt != '0);
            cntNext = 24'd1;
         end else if (cnt == '0) begin
            errSet = 1'b1;
         end else begin
            cntNext = cnt + 24'd1;
         end
         if (cntNext == 24'(FRAME_PIXELS)) begin
            doneNext = 1'b1;
            cntNext  = '0;
         end
      end
   end

   // output registers, latched mode, counter and sticky error
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         bus.oValid     <= 1'b0;
         bus.oSof       <= 1'b0;
         bus.oGaussData <= '0;
         bus.oDogData   <= '0;
         bus.oFrameDone <= 1'b0;
         bus.oSofErr    <= 1'b0;
         modeReg        <= 1'b0;
         cnt            <= '0;
      end else begin
         bus.oValid     <= alValid;
         bus.oSof       <= alValid && alSof;
         bus.oFrameDone <= doneNext;
         bus.oSofErr    <= bus.oSofErr || errSet;
         cnt            <= cntNext;
         if (alValid) begin
            bus.oGaussData <= alGauss;
            bus.oDogData   <= dogNext;
         end
         if (alValid && alSof) modeReg <= bus.iAbsMode;
      end
   end
endmodule

// File: tb/tb_dog_pyramid_align.sv
// tb_dog_pyramid_align: randomized and directed scoreboard bench with a frame-level reference model
module tb_dog_pyramid_align;
   localparam int DW   = 9;
   localparam int N    = 4;
   localparam int SKEW = 2;
   localparam int FP   = 4;
   localparam int D    = (N - 1) * SKEW;
   localparam int L    = D + 1;
   localparam int MAXC = 256;

   logic iclk   = 1'b0;
   logic irst_n = 1'b0;
   always #5 iclk = ~iclk;

   dog_pyramid_align_if #(.DW(DW), .NUM_SCALES(N)) bus ();
   dog_pyramid_align #(.DW(DW), .NUM_SCALES(N), .SKEW(SKEW), .FRAME_PIXELS(FP)) dut (
      .iclk(iclk), .irst_n(irst_n), .bus(bus)
   );

   typedef struct {
      int                       cyc;
      logic                     sof;
      logic [N*DW-1:0]          g;
      logic [(N-1)*(DW+1)-1:0]  dog;
      logic                     done;
      logic                     err;
   } exp_t;

   exp_t expQ[$];
   exp_t mon;
   int   cyc = 0;
   int   passCnt = 0;
   int   totalCnt = 0;
   bit   pv [MAXC+D];
   bit   ps [MAXC+D];
   bit   pa [MAXC+D];
   int   pg [MAXC+D][N];
   int   plen;
   int   mCnt;
   bit   mErr;
   bit   mMode;

   always @(posedge iclk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      totalCnt++;
      if (act === req) passCnt++;
      else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
   endtask

   // scoreboard monitor: every presented output is matched against the oldest prediction
   always @(negedge iclk) begin
      if (irst_n) begin
         if (bus.oValid) begin
            if (expQ.size() == 0) chk("unexpected oValid", 1, 0);
            else begin
               mon = expQ.pop_front();
               chk("latency", cyc, mon.cyc);
               chk("oSof", bus.oSof, mon.sof);
               chk("oGaussData", bus.oGaussData, mon.g);
               chk("oDogData", bus.oDogData, mon.dog);
               chk("oFrameDone", bus.oFrameDone, mon.done);
               chk("oSofErr", bus.oSofErr, mon.err);
            end
         end else begin
            chk("idle oSof", bus.oSof, 0);
            chk("idle oFrameDone", bus.oFrameDone, 0);
         end
      end
   end

   function automatic int rg();
      return ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 511 : 0) : int'($urandom_range(0, 511));
   endfunction

   task automatic clearPlan();
      plen = 0;
      for (int i = 0; i < MAXC + D; i++) pa[i] = bit'($urandom_range(0, 1));
   endtask

   task automatic addPix(input bit v, input bit s, input int a, input int g0, input int g1, input int g2, input int g3);
      pv[plen] = v;
      ps[plen] = s;
      pg[plen][0] = g0;
      pg[plen][1] = g1;
      pg[plen][2] = g2;
      pg[plen][3] = g3;
      if (a >= 0) pa[plen + D] = (a != 0);
      plen++;
   endtask

   task automatic addIdle();
      addPix(0, 0, -1, rg(), rg(), rg(), rg());
   endtask

   task automatic addRand();
      bit v;
      v = ($urandom_range(0, 9) < 6);
      addPix(v, v ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 7) == 0), -1, rg(), rg(), rg(), rg());
   endtask

   // reference model: frame rules applied to a pixel in issue order
   task automatic predict(input int c);
      exp_t e;
      int   diff;
      if (ps[c]) begin
         if (mCnt != 0) mErr = 1'b1;
         mCnt  = 1;
         mMode = pa[c + D];
      end else if (mCnt == 0) mErr = 1'b1;
      else mCnt++;
      e.done = (mCnt == FP);
      if (e.done) mCnt = 0;
      for (int k = 0; k < N; k++) e.g[k*DW +: DW] = DW'(pg[c][k]);
      for (int k = 0; k < N - 1; k++) begin
         diff = pg[c][k+1] - pg[c][k];
         if (mMode && diff < 0) diff = -diff;
         e.dog[k*(DW+1) +: DW+1] = (DW+1)'(diff);
      end
      e.cyc = cyc + 1 + D;
      e.sof = ps[c];
      e.err = mErr;
      expQ.push_back(e);
   endtask

   // drive plan cycles starting at the current negedge; scale k lags scale 0 by k*SKEW
   task automatic runPlan(input int ncyc);
      int idx;
      for (int c = 0; c < ncyc; c++) begin
         bus.iValid   = (c < plen) && pv[c];
         bus.iSof     = (c < plen) && ps[c];
         bus.iAbsMode = pa[c];
         for (int k = 0; k < N; k++) begin
            idx = c - k * SKEW;
            bus.iGaussData[k*DW +: DW] = (idx >= 0 && idx < plen) ? DW'(pg[idx][k]) : DW'($urandom);
         end
         if ((c < plen) && pv[c]) predict(c);
         @(negedge iclk);
      end
      bus.iValid = 1'b0;
      bus.iSof   = 1'b0;
   endtask

   task automatic play();
      runPlan(plen + D);
      repeat (L + 3) @(negedge iclk);
      chk("queue drained", expQ.size(), 0);
      chk("sticky oSofErr", bus.oSofErr, mErr);
   endtask

   task automatic chkZero(input string tag);
      chk({tag, " oValid"}, bus.oValid, 0);
      chk({tag, " oSof"}, bus.oSof, 0);
      chk({tag, " oGaussData"}, bus.oGaussData, 0);
      chk({tag, " oDogData"}, bus.oDogData, 0);
      chk({tag, " oFrameDone"}, bus.oFrameDone, 0);
      chk({tag, " oSofErr"}, bus.oSofErr, 0);
   endtask

   initial begin
      bus.iValid = 0; bus.iSof = 0; bus.iAbsMode = 0; bus.iGaussData = '0;
      mCnt = 0; mErr = 0; mMode = 0;
      repeat (3) @(negedge iclk);
      chkZero("reset");
      irst_n = 1'b1;
      clearPlan();
      addPix(1, 1, 0, 100, 120, 90, 300);
      addIdle();
      addPix(1, 0, -1, 511, 0, 7, 8);
      addIdle(); addIdle();
      addPix(1, 0, -1, 0, 511, 300, 1);
      addPix(1, 0, -1, 50, 50, 511, 0);
      addIdle(); addIdle();
      addPix(1, 1, 1, 100, 120, 90, 300);
      addPix(1, 0, 0, 511, 0, 3, 4);
      addPix(0, 0, 1, 9, 9, 9, 9);
      addPix(1, 0, 1, 0, 511, 200, 100);
      addPix(1, 0, 0, 12, 400, 3, 511);
      addIdle();
      addPix(1, 1, 0, 1, 2, 3, 4);
      addPix(1, 0, -1, 5, 6, 7, 8);
      addPix(1, 1, -1, 8, 7, 6, 5);
      addPix(1, 0, -1, 0, 511, 0, 511);
      addIdle();
      addPix(1, 0, -1, 511, 0, 511, 0);
      addPix(1, 0, -1, 30, 20, 10, 0);
      addPix(1, 0, -1, 44, 55, 66, 77);
      addPix(0, 1, -1, 1, 1, 1, 1);
      addPix(1, 1, 1, 0, 511, 511, 0);
      addPix(1, 0, -1, 511, 0, 0, 511);
      addPix(1, 0, -1, 200, 100, 300, 250);
      addPix(1, 0, -1, 7, 7, 7, 7);
      play();
      clearPlan();
      for (int i = 0; i < 120; i++) addRand();
      play();
      clearPlan();
      addPix(1, 1, -1, 10, 20, 30, 40);
      addPix(1, 0, -1, 40, 30, 20, 10);
      addPix(1, 0, -1, 5, 500, 5, 500);
      runPlan(4);
      #2 irst_n = 1'b0;
      #1 chkZero("async reset");
      expQ.delete();
      mCnt = 0; mErr = 0; mMode = 0;
      repeat (3) begin
         @(negedge iclk);
         bus.iValid = 1'b1; bus.iSof = 1'b1; bus.iGaussData = {N{9'h1AB}};
      end
      @(negedge iclk);
      irst_n = 1'b1;
      clearPlan();
      addPix(1, 1, 1, 300, 90, 120, 100);
      for (int i = 0; i < 80; i++) addRand();
      play();
      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end
endmodule

// File: doc/dog_pyramid_align.md
DOG_PYRAMID_ALIGN -- requirements
Module: dog_pyramid_align

Interface
REQ-001 Parameter DW, default 9: unsigned Gaussian pixel width, legal 8..12.
REQ-002 Parameter NUM_SCALES, default 4: Gaussian scale count N, legal 2..8; DoG count is N-1.
REQ-003 Parameter SKEW, default 2: per-scale arrival skew in clock cycles, legal 0..64.
REQ-004 Parameter FRAME_PIXELS, default 307200: valid pixels per frame, legal 2..2^24-1.
REQ-005 iclk  input  1  sole clock, all state on rising edge.
REQ-006 irst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 iValid  input  1  qualifies scale-0 pixel this cycle.
REQ-008 iSof  input  1  first pixel of frame, meaningful only with iValid.
REQ-009 iAbsMode  input  1  0 = signed DoG, 1 = absolute DoG.
REQ-010 iGaussData  input  N*DW  packed scales, scale k at bits [k*DW +: DW].
REQ-011 oValid  output  1  aligned pixel valid.
REQ-012 oSof  output  1  aligned start of frame, asserted only with oValid.
REQ-013 oGaussData  output  N*DW  aligned Gaussian scales, same packing as input.
REQ-014 oDogData  output  (N-1)*(DW+1)  DoG k at bits [k*(DW+1) +: DW+1].
REQ-015 oFrameDone  output  1  one-cycle pulse with last pixel of frame.
REQ-016 oSofErr  output  1  sticky framing error flag.

Function
REQ-017 Timing contract: pixel p with iValid/iSof/scale 0 at cycle t presents scale k at cycle t + k*SKEW; no backpressure exists.
REQ-018 Scale k shall pass a free-running delay of (N-1-k)*SKEW cycles (zero for k = N-1); iValid and iSof shall pass a (N-1)*SKEW delay.
REQ-019 Total latency L = (N-1)*SKEW + 1 cycles from iValid to oValid (default L = 7), fixed, independent of data.
REQ-020 DoG_k = G[k+1] - G[k], computed exactly in DW+1-bit two's complement; no saturation, no truncation.
REQ-021 Absolute mode: DoG_k = |G[k+1] - G[k]|, zero-extended to DW+1 bits.
REQ-022 Mode shall be sampled from iAbsMode on the aligned iSof pixel and held for the whole frame; mid-frame changes of iAbsMode have no effect until the next aligned iSof.
REQ-023 oGaussData, oDogData, oSof shall update only on cycles where aligned valid is 1; otherwise all hold their previous value and oSof = 0.
REQ-024 Frame counter (24 bits) advances on aligned valid: aligned iSof sets it to 1; other valid pixels increment it when it is nonzero.
REQ-025 When a valid pixel makes the count equal FRAME_PIXELS, oFrameDone = 1 in the same cycle as that pixel's oValid, and the counter returns to 0 (idle).
REQ-026 Aligned iSof while count is 1..FRAME_PIXELS-1 shall set oSofErr and restart the count at 1.
REQ-027 Aligned valid pixel without iSof while count is 0 shall set oSofErr; that pixel is still output but not counted.
REQ-028 iSof with iValid = 0 shall be ignored entirely.
REQ-029 oSofErr clears only on reset.
REQ-030 With SKEW = 0, no alignment storage exists and L = 1.

Reset
REQ-031 irst_n low shall asynchronously clear all outputs to 0, the latched mode to signed, the counter to 0, and all delay-line valid/sof bits to 0.
REQ-032 Data delay-line contents need not reset; no pixel in flight at reset shall produce oValid after release.
REQ-033 First iValid accepted in the first rising edge after irst_n deasserts shall appear on oValid L cycles later.

Verification
REQ-034 Defaults, signed mode, pixel scales (100,120,90,300) applied at skewed cycles t, t+2, t+4, t+6 with iSof -> at t+7 oValid = 1, oSof = 1, oDog = (20, 10'h3E2, 210), oGauss = (100,120,90,300).
REQ-035 Same pixel with iAbsMode = 1 at aligned iSof -> oDog = (20, 30, 210); iAbsMode toggled mid-frame -> mode unchanged until next iSof.
REQ-036 Extremes G0 = 511, G1 = 0 and G0 = 0, G1 = 511 -> DoG_0 = 10'h201 and 10'h1FF signed; 10'h1FF both in absolute mode.
REQ-037 FRAME_PIXELS = 4, four valid pixels starting with iSof, with gaps of idle cycles -> oFrameDone pulses exactly once, with 4th oValid; oSofErr stays 0.
REQ-038 FRAME_PIXELS = 4, iSof on 3rd pixel -> oSofErr = 1, done pulses with 4th pixel after that iSof; further valid pixel with count idle and no iSof -> oSofErr remains 1.
REQ-039 irst_n pulsed low while 3 pixels are in flight -> outputs 0 immediately, no oValid after release until L cycles after a fresh iValid.
